// File: rtl/vid_palette_loader.sv
// Palette write engine: queues CPU palette writes/fills from the bus and commits
// them to the 256x16 palette RAM write port, optionally only during vertical blanking.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  ST_IDLE  | waiting for a queued command and commit permission
//  ST_WRITE | single-entry commit, strobe issued next edge
//  ST_FILL  | range fill, one entry per cycle while commit is allowed
module vid_palette_loader #(
   parameter int FIFO_LOG2 = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [1:0]  wb_addr,
   input  logic [31:0] wb_wdata,
   output logic [31:0] wb_rdata,
   input  logic        wb_we,
   input  logic        wb_cyc,
   output logic        wb_ack,
   input  logic        vid_vbl,
   output logic [7:0]  w_addr_0,
   output logic [15:0] w_data_0,
   output logic        w_ena_0,
   output logic        busy
);

   localparam int DEPTH = 1 << FIFO_LOG2;

   typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_FILL} state_t;

   state_t state, state_nx;

   // entry layout: {op, end, start, colour}
   logic [32:0]        mem [DEPTH];
   logic [FIFO_LOG2:0] wr_ptr, rd_ptr, level;
   logic               empty, full;
   logic [32:0]        head, entry_in;

   logic        sync_vbl, flush_q, commit_ok;
   logic        bus_req, is_cmd, is_ctrl_wr, push, pop, ack_nx;
   logic        w_ena_nx;
   logic [7:0]  idx, cur_end;
   logic [15:0] cur_data;
   logic [31:0] status;

   assign level     = wr_ptr - rd_ptr;
   assign empty     = (level == '0);
   assign full      = level[FIFO_LOG2];
   assign head      = mem[rd_ptr[FIFO_LOG2-1:0]];
   assign commit_ok = !sync_vbl || vid_vbl;
   assign busy      = !empty || (state != ST_IDLE);

   assign bus_req    = wb_cyc && !wb_ack;
   assign is_cmd     = wb_we && !wb_addr[1];
   assign is_ctrl_wr = wb_we && (wb_addr == 2'd2);
   // a full FIFO stalls the ack until the engine pops in the same cycle
   assign ack_nx     = bus_req && (!is_cmd || !full || pop);
   assign push       = bus_req && is_cmd && (!full || pop);

   assign entry_in = wb_addr[0] ? {1'b1, wb_wdata[31:24], wb_wdata[23:16], wb_wdata[15:0]}
                                : {1'b0, wb_wdata[23:16], wb_wdata[23:16], wb_wdata[15:0]};

   assign status = {16'b0, 8'(level), 5'b0, full, busy, sync_vbl};

   always_comb begin
      state_nx = state;
      pop      = 1'b0;
      w_ena_nx = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!empty && commit_ok) begin
               pop      = 1'b1;
               state_nx = head[32] ? ST_FILL : ST_WRITE;
            end
         end
         ST_WRITE: begin
            w_ena_nx = 1'b1;
            state_nx = ST_IDLE;
         end
         ST_FILL: begin
            if (commit_ok) begin
               w_ena_nx = 1'b1;
               if (idx == cur_end) state_nx = ST_IDLE;
            end
         end
         default: state_nx = ST_IDLE;
      endcase
      if (flush_q) begin
         pop      = 1'b0;
         w_ena_nx = 1'b0;
         state_nx = ST_IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nx;
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[FIFO_LOG2-1:0]] <= entry_in;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (flush_q)  rd_ptr <= wr_ptr;
         else if (pop) rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_ack   <= 1'b0;
         wb_rdata <= '0;
         sync_vbl <= 1'b0;
         flush_q  <= 1'b0;
      end else begin
         wb_ack   <= ack_nx;
         wb_rdata <= (ack_nx && !wb_we && wb_addr == 2'd2) ? status : 32'd0;
         flush_q  <= ack_nx && is_ctrl_wr && wb_wdata[1];
         if (ack_nx && is_ctrl_wr) sync_vbl <= wb_wdata[0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx      <= '0;
         cur_end  <= '0;
         cur_data <= '0;
         w_ena_0  <= 1'b0;
         w_addr_0 <= '0;
         w_data_0 <= '0;
      end else begin
         if (pop) begin
            idx      <= head[23:16];
            cur_end  <= head[31:24];
            cur_data <= head[15:0];
         end else if (w_ena_nx && state == ST_FILL) begin
            idx <= idx + 8'd1;
         end
         w_ena_0 <= w_ena_nx;
         if (w_ena_nx) begin
            w_addr_0 <= idx;
            w_data_0 <= cur_data;
         end
      end
   end

endmodule

// File: tb/tb_vid_palette_loader.sv
// Directed bench for vid_palette_loader: strobes are checked against a scoreboard
// of expected {index, colour} pairs queued when each command is issued.
module tb_vid_palette_loader;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  wb_addr = '0;
   logic [31:0] wb_wdata = '0;
   logic [31:0] wb_rdata;
   logic        wb_we = 1'b0;
   logic        wb_cyc = 1'b0;
   logic        wb_ack;
   logic        vid_vbl = 1'b0;
   logic [7:0]  w_addr_0;
   logic [15:0] w_data_0;
   logic        w_ena_0;
   logic        busy;

   int total = 0;
   int bad = 0;
   int cyc_n = 0;
   int strobes = 0;
   int last_strobe_cyc = -1;
   int strobe_cyc_q[$];
   logic [23:0] sb[$];
   logic sb_on = 1'b1;

   vid_palette_loader #(.FIFO_LOG2(4)) dut (
      .clk(clk), .rst_n(rst_n), .wb_addr(wb_addr), .wb_wdata(wb_wdata),
      .wb_rdata(wb_rdata), .wb_we(wb_we), .wb_cyc(wb_cyc), .wb_ack(wb_ack),
      .vid_vbl(vid_vbl), .w_addr_0(w_addr_0), .w_data_0(w_data_0),
      .w_ena_0(w_ena_0), .busy(busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc_n <= cyc_n + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   always @(posedge clk) begin
      #1;
      if (rst_n && w_ena_0) begin
         strobes++;
         last_strobe_cyc = cyc_n;
         strobe_cyc_q.push_back(cyc_n);
         if (sb_on) begin
            if (sb.size() == 0) check("unexpected_strobe", {8'd0, w_addr_0, w_data_0}, 32'hFFFFFFFF);
            else check("strobe", {8'd0, w_addr_0, w_data_0}, {8'd0, sb.pop_front()});
         end
      end
   end

   task automatic bus(input logic [1:0] a, input logic we, input logic [31:0] d,
                      output logic [31:0] rd, output int ackc);
      logic got;
      got = 1'b0;
      @(negedge clk);
      wb_addr = a; wb_we = we; wb_wdata = d; wb_cyc = 1'b1;
      for (int i = 0; i < 200 && !got; i++) begin
         @(negedge clk);
         if (wb_ack) got = 1'b1;
      end
      if (!got) check("bus_ack_timeout", 32'd0, 32'd1);
      rd = wb_rdata;
      ackc = cyc_n;
      wb_cyc = 1'b0;
   endtask

   task automatic wcmd(input logic [1:0] a, input logic [31:0] d, output int ackc);
      logic [31:0] rd;
      bus(a, 1'b1, d, rd, ackc);
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_idle(input string tag);
      logic done;
      done = 1'b0;
      for (int i = 0; i < 3000 && !done; i++) begin
         @(negedge clk);
         if (!busy) done = 1'b1;
      end
      if (!done) check(tag, 32'd1, 32'd0);
      wait_cyc(3);
   endtask

   initial begin
      int ackc, base, n0;
      logic [31:0] rd;
      logic got;

      // reset state
      #12;
      check("rst_w_ena", {31'd0, w_ena_0}, 32'd0);
      check("rst_w_addr", {24'd0, w_addr_0}, 32'd0);
      check("rst_w_data", {16'd0, w_data_0}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_ack", {31'd0, wb_ack}, 32'd0);
      check("rst_rdata", wb_rdata, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      bus(2'd2, 1'b0, 32'd0, rd, ackc);
      check("status_after_reset", rd, 32'd0);

      // 1: immediate write, latency 2 cycles after ack
      wcmd(2'd2, 32'd0, ackc);
      sb.push_back({8'h05, 16'hF800});
      wcmd(2'd0, 32'h0005F800, ackc);
      wait_idle("t1_idle_timeout");
      check("t1_latency", last_strobe_cyc, ackc + 2);
      check("t1_count", strobes, 1);

      // 2: blanking-gated writes
      wcmd(2'd2, 32'd1, ackc);
      vid_vbl = 1'b0;
      for (int i = 0; i < 3; i++) begin
         sb.push_back({8'(8'h20 + i), 16'(16'h1000 + i)});
         wcmd(2'd0, {8'd0, 8'(8'h20 + i), 16'(16'h1000 + i)}, ackc);
      end
      wait_cyc(10);
      check("t2_no_strobe", strobes, 1);
      bus(2'd2, 1'b0, 32'd0, rd, ackc);
      check("t2_status", rd, 32'h00000303);
      vid_vbl = 1'b1;
      wait_idle("t2_idle_timeout");
      check("t2_count", strobes, 4);
      check("t2_busy", {31'd0, busy}, 32'd0);

      // 3: wrapping fill FE..01
      base = strobes;
      for (int i = 0; i < 4; i++) sb.push_back({8'(8'hFE + i), 16'h07E0});
      wcmd(2'd1, 32'h01FE07E0, ackc);
      wait_idle("t3_idle_timeout");
      check("t3_count", strobes - base, 4);
      check("t3_consecutive", strobe_cyc_q[base+3] - strobe_cyc_q[base], 3);

      // 4: full-range fill paused by blanking drop after 100 entries
      base = strobes;
      for (int i = 0; i < 256; i++) sb.push_back({8'(i), 16'h1234});
      wcmd(2'd1, 32'hFF001234, ackc);
      got = 1'b0;
      for (int i = 0; i < 1000 && !got; i++) begin
         @(negedge clk);
         if (strobes - base == 100) begin
            vid_vbl = 1'b0;
            got = 1'b1;
         end
      end
      if (!got) check("t4_reach100_timeout", 32'd0, 32'd1);
      wait_cyc(20);
      check("t4_paused", strobes - base, 100);
      check("t4_busy_paused", {31'd0, busy}, 32'd1);
      vid_vbl = 1'b1;
      wait_idle("t4_idle_timeout");
      check("t4_total", strobes - base, 256);

      // 5: fill the FIFO, stall the 17th write, release with blanking
      vid_vbl = 1'b0;
      base = strobes;
      for (int i = 0; i < 16; i++) begin
         sb.push_back({8'(8'h40 + i), 16'(16'hA000 + i)});
         wcmd(2'd0, {8'd0, 8'(8'h40 + i), 16'(16'hA000 + i)}, ackc);
      end
      bus(2'd2, 1'b0, 32'd0, rd, ackc);
      check("t5_status_full", rd, 32'h00001007);
      sb.push_back({8'h50, 16'hA010});
      @(negedge clk);
      wb_addr = 2'd0; wb_we = 1'b1; wb_wdata = 32'h0050A010; wb_cyc = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (wb_ack) got = 1'b1;
      end
      check("t5_ack_stalled", {31'd0, got}, 32'd0);
      vid_vbl = 1'b1;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (wb_ack) got = 1'b1;
      end
      check("t5_ack_after_pop", {31'd0, got}, 32'd1);
      wb_cyc = 1'b0;
      wait_idle("t5_idle_timeout");
      check("t5_count", strobes - base, 17);
      check("sb_empty", sb.size(), 0);

      // 6: flush mid-fill, then reset mid-fill
      sb_on = 1'b0;
      wcmd(2'd2, 32'd0, ackc);
      base = strobes;
      wcmd(2'd1, 32'hFF00AAAA, ackc);
      got = 1'b0;
      for (int i = 0; i < 200 && !got; i++) begin
         @(negedge clk);
         if (strobes - base >= 20) got = 1'b1;
      end
      if (!got) check("t6_fill_timeout", 32'd0, 32'd1);
      wcmd(2'd2, 32'd2, ackc);
      n0 = strobes;
      wait_cyc(10);
      check("t6_flush_stops", strobes, n0);
      check("t6_flush_busy", {31'd0, busy}, 32'd0);
      bus(2'd2, 1'b0, 32'd0, rd, ackc);
      check("t6_flush_status", rd, 32'd0);
      wcmd(2'd1, 32'hFF005555, ackc);
      wait_cyc(30);
      check("t6_fill_running", {31'd0, w_ena_0}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("t6_rst_w_ena", {31'd0, w_ena_0}, 32'd0);
      check("t6_rst_w_addr", {24'd0, w_addr_0}, 32'd0);
      check("t6_rst_w_data", {16'd0, w_data_0}, 32'd0);
      check("t6_rst_busy", {31'd0, busy}, 32'd0);
      check("t6_rst_rdata", wb_rdata, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      n0 = strobes;
      bus(2'd2, 1'b0, 32'd0, rd, ackc);
      check("t6_post_rst_status", rd, 32'd0);
      wait_cyc(5);
      check("t6_post_rst_no_strobe", strobes, n0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
